// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with capture-time EX/MEM forwarding,
// load-use bubble insertion, downstream stall and flush.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall_in,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [5:0]    id_ALUFun,
    input  logic          id_Sign,
    input  logic          id_ALUSrcA,
    input  logic          id_ALUSrcB,
    input  logic [4:0]    id_shamt,
    input  logic [DW-1:0] id_imm,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [AW-1:0] id_rd,
    input  logic          id_RegWrite,
    input  logic          id_MemRead,
    input  logic          id_MemWrite,
    input  logic          id_MemToReg,
    input  logic [DW-1:0] ex_alu_result,
    input  logic          mem_RegWrite,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic          ex_valid,
    output logic [DW-1:0] ex_A,
    output logic [DW-1:0] ex_B,
    output logic [5:0]    ex_ALUFun,
    output logic          ex_Sign,
    output logic [DW-1:0] ex_store_data,
    output logic [AW-1:0] ex_rd,
    output logic          ex_RegWrite,
    output logic          ex_MemRead,
    output logic          ex_MemWrite,
    output logic          ex_MemToReg,
    output logic          load_use_stall
);
    typedef struct packed {
        logic          valid;
        logic [5:0]    alufun;
        logic          sign;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] store;
        logic [AW-1:0] rd;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
        logic          memtoreg;
    } stage_t;

    stage_t        r_ex, w_next;
    logic          w_ex_fwd_ok, w_mem_fwd_ok;
    logic [DW-1:0] w_fwd_rs, w_fwd_rt;

    always_comb begin
        // a load's ex_alu_result is an address, never the loaded value
        w_ex_fwd_ok     = r_ex.valid & r_ex.regwrite & ~r_ex.memread & (r_ex.rd != '0);
        w_mem_fwd_ok    = mem_RegWrite & (mem_rd != '0);
        w_fwd_rs        = (w_ex_fwd_ok & (r_ex.rd == id_rs)) ? ex_alu_result :
                          (w_mem_fwd_ok & (mem_rd == id_rs)) ? mem_data : id_rs_data;
        w_fwd_rt        = (w_ex_fwd_ok & (r_ex.rd == id_rt)) ? ex_alu_result :
                          (w_mem_fwd_ok & (mem_rd == id_rt)) ? mem_data : id_rt_data;
        load_use_stall  = id_valid & r_ex.valid & r_ex.memread & (r_ex.rd != '0) &
                          ((id_uses_rs & (r_ex.rd == id_rs)) | (id_uses_rt & (r_ex.rd == id_rt)));
        w_next.valid    = id_valid;
        w_next.alufun   = id_ALUFun;
        w_next.sign     = id_Sign;
        w_next.a        = id_ALUSrcA ? {{(DW-5){1'b0}}, id_shamt} : w_fwd_rs;
        w_next.b        = id_ALUSrcB ? id_imm : w_fwd_rt;
        w_next.store    = w_fwd_rt;
        w_next.rd       = id_rd;
        w_next.regwrite = id_valid & id_RegWrite;
        w_next.memread  = id_valid & id_MemRead;
        w_next.memwrite = id_valid & id_MemWrite;
        w_next.memtoreg = id_valid & id_MemToReg;
    end

    // a held stage wins over a load-use bubble; flush always bubbles
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ex <= '0;
        else if (flush | (~stall_in & load_use_stall))
            r_ex <= '0;
        else if (~stall_in)
            r_ex <= w_next;
    end

    assign ex_valid      = r_ex.valid;
    assign ex_A          = r_ex.a;
    assign ex_B          = r_ex.b;
    assign ex_ALUFun     = r_ex.alufun;
    assign ex_Sign       = r_ex.sign;
    assign ex_store_data = r_ex.store;
    assign ex_rd         = r_ex.rd;
    assign ex_RegWrite   = r_ex.regwrite;
    assign ex_MemRead    = r_ex.memread;
    assign ex_MemWrite   = r_ex.memwrite;
    assign ex_MemToReg   = r_ex.memtoreg;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage forwarding,
// load-use bubbling, stall and flush.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0, reset, stall_in, flush;
    logic          id_valid, id_Sign, id_ALUSrcA, id_ALUSrcB;
    logic [5:0]    id_ALUFun;
    logic [4:0]    id_shamt;
    logic [DW-1:0] id_imm, id_rs_data, id_rt_data, ex_alu_result, mem_data;
    logic [AW-1:0] id_rs, id_rt, id_rd, mem_rd;
    logic          id_uses_rs, id_uses_rt, id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg;
    logic          mem_RegWrite;
    logic          ex_valid, ex_Sign, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg;
    logic          load_use_stall;
    logic [DW-1:0] ex_A, ex_B, ex_store_data;
    logic [5:0]    ex_ALUFun;
    logic [AW-1:0] ex_rd;
    int            checks = 0, errors = 0;

    id_ex_stage #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush(flush),
        .id_valid(id_valid), .id_ALUFun(id_ALUFun), .id_Sign(id_Sign),
        .id_ALUSrcA(id_ALUSrcA), .id_ALUSrcB(id_ALUSrcB), .id_shamt(id_shamt),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_rd(id_rd),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_MemToReg(id_MemToReg),
        .ex_alu_result(ex_alu_result), .mem_RegWrite(mem_RegWrite),
        .mem_rd(mem_rd), .mem_data(mem_data),
        .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_ALUFun(ex_ALUFun),
        .ex_Sign(ex_Sign), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_MemToReg(ex_MemToReg),
        .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_in = 0; flush = 0; id_valid = 0; id_ALUFun = 0; id_Sign = 0;
        id_ALUSrcA = 0; id_ALUSrcB = 0; id_shamt = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_rs_data = 0; id_rt_data = 0; id_rd = 0;
        id_RegWrite = 0; id_MemRead = 0; id_MemWrite = 0; id_MemToReg = 0;
        ex_alu_result = 0; mem_RegWrite = 0; mem_rd = 0; mem_data = 0;
    endtask

    task automatic alu_op(input logic [AW-1:0] rd, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic [DW-1:0] rs_d, input logic [DW-1:0] rt_d);
        id_valid = 1; id_RegWrite = 1; id_MemRead = 0; id_MemToReg = 0; id_MemWrite = 0;
        id_rd = rd; id_rs = rs; id_rt = rt; id_uses_rs = 1; id_uses_rt = 1;
        id_rs_data = rs_d; id_rt_data = rt_d; id_ALUSrcA = 0; id_ALUSrcB = 0;
    endtask

    task automatic test_reset();
        idle();
        alu_op(5'd3, 5'd1, 5'd2, 32'h1234, 32'h5678);
        id_ALUFun = 6'h21;
        tick();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", ex_valid); end
        #2 reset = 1;
        #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", ex_valid); end
        checks++; if (ex_A !== 32'h0 || ex_B !== 32'h0) begin errors++; $display("FAIL async_reset_ab: got %h/%h expected 0/0", ex_A, ex_B); end
        checks++; if (ex_ALUFun !== 6'h0 || ex_rd !== 5'd0 || ex_RegWrite !== 1'b0) begin errors++; $display("FAIL async_reset_ctl: got fun %h rd %0d rw %b expected 0", ex_ALUFun, ex_rd, ex_RegWrite); end
        @(negedge clk) reset = 0;
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_A !== 32'h1234 || ex_rd !== 5'd3) begin errors++; $display("FAIL post_reset_capture: got v%b A %h rd %0d expected v1 A 1234 rd 3", ex_valid, ex_A, ex_rd); end
    endtask

    task automatic test_ex_forward();
        idle();
        alu_op(5'd3, 5'd1, 5'd2, 32'h7, 32'h9);
        tick();
        ex_alu_result = 32'h10;
        alu_op(5'd4, 5'd3, 5'd3, 32'hDEAD, 32'hBEEF);
        #1;
        checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL ex_fwd_no_stall: got %b expected 0", load_use_stall); end
        tick();
        checks++; if (ex_A !== 32'h10 || ex_B !== 32'h10) begin errors++; $display("FAIL ex_fwd_ab: got %h/%h expected 10/10", ex_A, ex_B); end
        checks++; if (ex_store_data !== 32'h10 || ex_rd !== 5'd4) begin errors++; $display("FAIL ex_fwd_store: got %h rd %0d expected 10 rd 4", ex_store_data, ex_rd); end
    endtask

    task automatic test_priority();
        idle();
        alu_op(5'd5, 5'd1, 5'd2, 32'h0, 32'h0);
        tick();
        ex_alu_result = 32'h1; mem_RegWrite = 1; mem_rd = 5'd5; mem_data = 32'h2;
        alu_op(5'd8, 5'd5, 5'd5, 32'h33, 32'h44);
        id_RegWrite = 0;
        tick();
        checks++; if (ex_A !== 32'h1) begin errors++; $display("FAIL ex_over_mem: got %h expected 1", ex_A); end
        ex_alu_result = 32'h77;
        tick();
        checks++; if (ex_B !== 32'h2) begin errors++; $display("FAIL mem_fwd: got %h expected 2", ex_B); end
    endtask

    task automatic test_load_use();
        idle();
        alu_op(5'd6, 5'd2, 5'd2, 32'h100, 32'h0);
        id_MemRead = 1; id_MemToReg = 1; id_uses_rt = 0;
        tick();
        alu_op(5'd7, 5'd6, 5'd1, 32'h1111, 32'h22);
        id_ALUFun = 6'h01; ex_alu_result = 32'h9999;
        #1;
        checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL load_use_flag: got %b expected 1", load_use_stall); end
        stall_in = 1;
        tick();
        checks++; if (ex_MemRead !== 1'b1 || ex_rd !== 5'd6) begin errors++; $display("FAIL stall_over_lu: got mr %b rd %0d expected mr 1 rd 6", ex_MemRead, ex_rd); end
        stall_in = 0;
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_RegWrite !== 1'b0 || ex_ALUFun !== 6'h0 || ex_A !== 32'h0 || ex_rd !== 5'd0) begin errors++; $display("FAIL lu_bubble: got v%b rw%b fun %h A %h rd %0d expected all 0", ex_valid, ex_RegWrite, ex_ALUFun, ex_A, ex_rd); end
        mem_RegWrite = 1; mem_rd = 5'd6; mem_data = 32'hABCD;
        #1;
        checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_single: got %b expected 0", load_use_stall); end
        tick();
        checks++; if (ex_A !== 32'hABCD || ex_B !== 32'h22) begin errors++; $display("FAIL lu_mem_fwd: got %h/%h expected abcd/22", ex_A, ex_B); end
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_ALUFun !== 6'h01) begin errors++; $display("FAIL lu_resume: got v%b rd %0d fun %h expected v1 rd 7 fun 01", ex_valid, ex_rd, ex_ALUFun); end
    endtask

    task automatic test_r0();
        idle();
        alu_op(5'd0, 5'd1, 5'd2, 32'h0, 32'h0);
        tick();
        ex_alu_result = 32'hFFFF; mem_RegWrite = 1; mem_rd = 5'd0; mem_data = 32'hFFFF;
        alu_op(5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
        id_MemRead = 1;
        tick();
        checks++; if (ex_A !== 32'h0 || ex_B !== 32'h0) begin errors++; $display("FAIL r0_no_fwd: got %h/%h expected 0/0", ex_A, ex_B); end
        #1;
        checks++; if (load_use_stall !== 1'b0 || ex_MemRead !== 1'b1) begin errors++; $display("FAIL r0_no_stall: got lu %b mr %b expected lu 0 mr 1", load_use_stall, ex_MemRead); end
    endtask

    task automatic test_stall_flush();
        idle();
        alu_op(5'd9, 5'd1, 5'd2, 32'h55, 32'h66);
        id_ALUFun = 6'h22;
        tick();
        stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            alu_op(5'(10 + i), 5'd3, 5'd4, 32'(i), 32'(i + 8));
            id_ALUFun = 6'(i);
            tick();
            checks++; if (ex_rd !== 5'd9 || ex_A !== 32'h55 || ex_B !== 32'h66 || ex_ALUFun !== 6'h22) begin errors++; $display("FAIL stall_hold%0d: got rd %0d A %h B %h fun %h expected rd 9 A 55 B 66 fun 22", i, ex_rd, ex_A, ex_B, ex_ALUFun); end
        end
        flush = 1;
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_RegWrite !== 1'b0) begin errors++; $display("FAIL flush_stall: got v%b rd %0d rw %b expected 0", ex_valid, ex_rd, ex_RegWrite); end
        stall_in = 0; flush = 0;
        alu_op(5'd12, 5'd1, 5'd2, 32'h3, 32'h4);
        id_ALUSrcA = 1; id_shamt = 5'd5; id_ALUSrcB = 1; id_imm = 32'hFFFFFFF0;
        tick();
        checks++; if (ex_B !== 32'hFFFFFFF0 || ex_A !== 32'h5 || ex_store_data !== 32'h4) begin errors++; $display("FAIL imm_shamt: got A %h B %h sd %h expected 5 fffffff0 4", ex_A, ex_B, ex_store_data); end
    endtask

    task automatic test_invalid_gating();
        idle();
        id_RegWrite = 1; id_MemWrite = 1; id_MemRead = 1; id_MemToReg = 1; id_rd = 5'd3;
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_RegWrite !== 1'b0 || ex_MemWrite !== 1'b0 || ex_MemRead !== 1'b0 || ex_MemToReg !== 1'b0) begin errors++; $display("FAIL invalid_gate: got v%b rw%b mw%b mr%b m2r%b expected 0", ex_valid, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_MemToReg); end
    endtask

    initial begin
        idle();
        reset = 1;
        repeat (2) tick();
        checks++; if (ex_valid !== 1'b0 || ex_ALUFun !== 6'h0) begin errors++; $display("FAIL init_reset: got v%b fun %h expected 0", ex_valid, ex_ALUFun); end
        @(negedge clk) reset = 0;
        test_reset();
        test_ex_forward();
        test_priority();
        test_load_use();
        test_r0();
        test_stall_flush();
        test_invalid_gating();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
